// File: rtl/trace_seq_pkg.sv
// Shared types for the trace stimulus sequencer: FSM states, cycle counter type, default depth.
// Optional build macro used by the top: TRACE_SEQ_CONT_ON_FAIL_EN.
package trace_seq_pkg;

  localparam int SEQ_DEPTH_DEFAULT   = 16;
  localparam int SEQ_CYCLE_W_DEFAULT = 32;

  typedef logic [SEQ_CYCLE_W_DEFAULT-1:0] cycle_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOADING,
    SEQ_ARMED,
    SEQ_RUN,
    SEQ_PASS,
    SEQ_FAIL
  } seq_state_e;

endpackage

// File: rtl/trace_seq_mem.sv
// Stimulus vector store: DEPTH x WIDTH, synchronous write, combinational read.
module trace_seq_mem #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array; contents are only read after being written, so
  // reset logic would add cost without changing behaviour.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_stim_sequencer.sv
// Replays a loaded list of input vectors into a formal-trace DUT and reports pass/fail.
// Build option TRACE_SEQ_CONT_ON_FAIL_EN: keep replaying after a fail and count fails.
module trace_stim_sequencer
  import trace_seq_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int DEPTH   = SEQ_DEPTH_DEFAULT,
  parameter int CYCLE_W = SEQ_CYCLE_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               load_last,
  input  logic               start,
  input  logic               flush,
  input  logic               dut_fail,
  output logic [WIDTH-1:0]   stim_out,
  output logic               stim_valid,
  output logic               running,
  output logic               done,
  output logic               failed,
  output logic [CYCLE_W-1:0] cycle,
  output logic [CYCLE_W-1:0] fail_cycle
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
  ,
  output logic [CYCLE_W-1:0] fail_count
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  seq_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_addr;
  logic [WIDTH-1:0]   rd_data;
  logic               load_fire;
  logic               last_vec;
  logic [CYCLE_W-1:0] count_ext;

  assign load_ready = ((state == SEQ_IDLE) || (state == SEQ_LOADING)) && (count < CNT_W'(DEPTH));
  assign load_fire  = load_valid & load_ready;
  assign running    = (state == SEQ_RUN);
  assign done       = (state == SEQ_PASS) || (state == SEQ_FAIL);
  assign failed     = (state == SEQ_FAIL);
  assign count_ext  = CYCLE_W'(count);
  assign last_vec   = (cycle + CYCLE_W'(1)) == count_ext;

  // During RUN fetch the next vector; otherwise present mem[0] ready for start.
  assign rd_addr = running ? (cycle[AW-1:0] + AW'(1)) : '0;

  trace_seq_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (load_fire && !flush),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SEQ_IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      stim_out   <= '0;
      stim_valid <= 1'b0;
      cycle      <= '0;
      fail_cycle <= '0;
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
      fail_count <= '0;
`endif
    end else begin
      case (state)
        SEQ_IDLE, SEQ_LOADING: begin
          if (flush) begin
            state  <= SEQ_IDLE;
            count  <= '0;
            wr_ptr <= '0;
          end else if (load_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CNT_W'(1);
            state  <= (load_last || (wr_ptr == AW'(DEPTH - 1))) ? SEQ_ARMED : SEQ_LOADING;
          end
        end

        SEQ_ARMED, SEQ_PASS, SEQ_FAIL: begin
          if (flush) begin
            state  <= SEQ_IDLE;
            count  <= '0;
            wr_ptr <= '0;
          end else if (start) begin
            state      <= SEQ_RUN;
            cycle      <= '0;
            stim_out   <= rd_data;
            stim_valid <= 1'b1;
            fail_cycle <= '0;
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
            fail_count <= '0;
`endif
          end
        end

        SEQ_RUN: begin
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
          if (dut_fail) begin
            fail_count <= fail_count + CYCLE_W'(1);
            if (fail_count == '0) fail_cycle <= cycle;
          end
          if (last_vec) begin
            state      <= (dut_fail || (fail_count != '0)) ? SEQ_FAIL : SEQ_PASS;
            stim_valid <= 1'b0;
            cycle      <= count_ext;
          end else begin
            cycle    <= cycle + CYCLE_W'(1);
            stim_out <= rd_data;
          end
`else
          if (dut_fail) begin
            state      <= SEQ_FAIL;
            fail_cycle <= cycle;
            stim_valid <= 1'b0;
          end else if (last_vec) begin
            state      <= SEQ_PASS;
            stim_valid <= 1'b0;
            cycle      <= count_ext;
          end else begin
            cycle    <= cycle + CYCLE_W'(1);
            stim_out <= rd_data;
          end
`endif
        end

        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_stim_sequencer.sv
// Self-checking bench for trace_stim_sequencer: directed scenarios plus randomized load/replay runs.
module tb_trace_stim_sequencer;
  import trace_seq_pkg::*;

  localparam int WIDTH   = 1;
  localparam int DEPTH   = 4;
  localparam int CYCLE_W = 32;

  logic             clock = 1'b0;
  logic             reset, load_valid, load_last, start, flush, dut_fail;
  logic [WIDTH-1:0] load_data, stim_out;
  logic             load_ready, stim_valid, running, done, failed;
  cycle_t           cycle, fail_cycle;
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
  cycle_t           fail_count;
`endif

  trace_stim_sequencer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .CYCLE_W (CYCLE_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .start      (start),
    .flush      (flush),
    .dut_fail   (dut_fail),
    .stim_out   (stim_out),
    .stim_valid (stim_valid),
    .running    (running),
    .done       (done),
    .failed     (failed),
    .cycle      (cycle),
    .fail_cycle (fail_cycle)
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
    ,
    .fail_count (fail_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] vecs[$];     // vectors the model believes are stored
  logic [WIDTH-1:0] pending[$];  // vectors about to be offered

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers every pending vector; load_last on the final one when use_last is set.
  task automatic load_pending(input bit use_last);
    vecs.delete();
    foreach (pending[i]) begin
      check("load_ready_before_write", load_ready, 1);
      load_valid = 1'b1;
      load_data  = pending[i];
      load_last  = use_last && (i == pending.size() - 1);
      tick();
      vecs.push_back(pending[i]);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("load_ready_when_armed", load_ready, 0);
    check("armed_not_done", done, 0);
  endtask

  // Replays the stored set; fail_mask bit k raises dut_fail while vector k is presented.
  task automatic run_replay(input logic [DEPTH-1:0] fail_mask);
    int n, first, nfail, last_k;
    n     = vecs.size();
    first = -1;
    nfail = 0;
    for (int k = 0; k < n; k++) begin
      if (fail_mask[k]) begin
        nfail++;
        if (first < 0) first = k;
      end
    end
    last_k = n - 1;
`ifndef TRACE_SEQ_CONT_ON_FAIL_EN
    if (first >= 0) last_k = first;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      check("run_running", running, 1);
      check("run_stim_valid", stim_valid, 1);
      check("run_stim_out", stim_out, vecs[k]);
      check("run_cycle", cycle, k);
      dut_fail = fail_mask[k];
      tick();
    end
    dut_fail = 1'b0;
    check("end_running", running, 0);
    check("end_done", done, 1);
    check("end_failed", failed, first >= 0);
    check("end_stim_valid", stim_valid, 0);
    check("end_stim_out_held", stim_out, vecs[last_k]);
    check("end_fail_cycle", fail_cycle, (first >= 0) ? first : 0);
`ifdef TRACE_SEQ_CONT_ON_FAIL_EN
    check("end_cycle", cycle, n);
    check("end_fail_count", fail_count, nfail);
`else
    check("end_cycle", cycle, (first >= 0) ? first : n);
`endif
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_load_ready", load_ready, 1);
    check("flush_not_done", done, 0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    start = 1'b0; flush = 1'b0; dut_fail = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_stim_out", stim_out, 0);
    check("rst_stim_valid", stim_valid, 0);
    check("rst_cycle", cycle, 0);
    check("rst_fail_cycle", fail_cycle, 0);
    check("rst_done", done, 0);
    check("rst_load_ready", load_ready, 1);

    // Load 0,1,1,0 and replay cleanly, then with a fail on index 2.
    pending = '{1'b0, 1'b1, 1'b1, 1'b0};
    load_pending(1'b1);
    run_replay('0);
    run_replay(4'b0100);
    // Restart from FAIL, then flush+start together from PASS: flush wins.
    run_replay('0);
    flush = 1'b1;
    start = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    check("flush_start_running", running, 0);
    check("flush_start_done", done, 0);
    check("flush_start_load_ready", load_ready, 1);
    tick();
    check("flush_start_still_idle", running, 0);

    // Five vectors offered without load_last: only four accepted.
    pending = '{1'b1, 1'b0, 1'b1, 1'b1};
    load_pending(1'b0);
    load_valid = 1'b1;
    load_data  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fifth_not_ready", load_ready, 0);
      tick();
    end
    load_valid = 1'b0;
    check("fifth_not_running", running, 0);
    run_replay('0);

    // Reset while running at cycle 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_cycle", cycle, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_rst_stim_out", stim_out, 0);
    check("midrun_rst_stim_valid", stim_valid, 0);
    check("midrun_rst_cycle", cycle, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_running", running, 0);
    check("midrun_rst_load_ready", load_ready, 1);

    // Fails at indices 1 and 3.
    pending = '{1'b1, 1'b1, 1'b0, 1'b1};
    load_pending(1'b1);
    run_replay(4'b1010);

    // Randomized load lengths, data and fail patterns.
    for (int it = 0; it < 30; it++) begin
      int n;
      bit use_last;
      do_flush();
      n = $urandom_range(1, DEPTH);
      pending.delete();
      for (int i = 0; i < n; i++) pending.push_back(WIDTH'($urandom));
      use_last = (n < DEPTH) ? 1'b1 : 1'($urandom);
      load_pending(use_last);
      for (int r = 0; r < 2; r++) begin
        logic [DEPTH-1:0] mask;
        mask = ($urandom_range(0, 1) == 0) ? '0 : DEPTH'($urandom);
        run_replay(mask);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_stim_sequencer.md
Name: trace_stim_sequencer

Overview:
Replays a loaded list of primary-input vectors into a formal-trace DUT, one vector per clock, then reports pass or fail.
- Fail comes from the DUT's assertion-failure flag.
- Sits between the trace testbench top and the DUT. It replaces hand-written per-state initial blocks and handles clock-stop accounting.
- One DUT input bus is replayed per run.

Parameters:
WIDTH, 1, width of one stimulus vector (DUT primary-input bus)
DEPTH, 16, maximum number of stored vectors (power of two, >= 2)
CYCLE_W, 32, width of cycle and fail_cycle counters

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
load_valid  in  1  vector write request
load_ready  out  1  sequencer can accept a vector
load_data  in  WIDTH  vector to store
load_last  in  1  accepted vector is the final one
start  in  1  begin or repeat replay
flush  in  1  discard stored vectors, return to IDLE
dut_fail  in  1  DUT assertion-failure flag, sampled each RUN cycle
stim_out  out  WIDTH  vector driven to the DUT
stim_valid  out  1  stim_out is a live replay vector
running  out  1  state == RUN
done  out  1  state is PASS or FAIL
failed  out  1  state == FAIL
cycle  out  CYCLE_W  index of the vector currently presented; equals count after PASS
fail_cycle  out  CYCLE_W  index at which dut_fail was first sampled high

Behaviour:
- States: IDLE, LOADING, ARMED, RUN, PASS, FAIL. State register and all outputs are registered except load_ready, running, done and failed, which are decoded from state.
- Reset (any state, including mid-RUN):
  - state=IDLE, count=0, wr_ptr=0.
  - stim_out=0, stim_valid=0, cycle=0, fail_cycle=0.
  - Memory contents are don't-care.
- load_ready=1 in IDLE and LOADING only, and only while count<DEPTH.
- Load handshake (load_valid & load_ready):
  - mem[wr_ptr]<=load_data, wr_ptr++, count++.
  - IDLE goes to LOADING.
  - If load_last, or the write lands at index DEPTH-1, go to ARMED. load_last is ignored unless the handshake completes.
- start is honoured in ARMED, PASS and FAIL; it is ignored elsewhere. On that edge:
  - state=RUN, cycle<=0.
  - stim_out<=mem[0], stim_valid<=1, fail_cycle<=0.
- RUN, with cycle=k and stim_out=mem[k], at each edge:
  - dut_fail=1: go to FAIL, fail_cycle<=k, stim_valid<=0, stim_out holds, cycle holds.
  - else k==count-1: go to PASS, stim_valid<=0, stim_out holds, cycle<=count.
  - else cycle<=k+1, stim_out<=mem[k+1].
  - dut_fail on the last vector yields FAIL, not PASS.
- Latency: first vector appears 1 cycle after start is sampled. A run of N vectors ends N cycles after it starts.
- flush: any non-RUN state goes to IDLE with count=0 and wr_ptr=0. flush is ignored in RUN.
- flush and start in the same cycle: flush wins.
- Counters never wrap: count<=DEPTH, and cycle<=DEPTH fits CYCLE_W.

Optional Feature:
TRACE_SEQ_CONT_ON_FAIL_EN
- Defined:
  - A dut_fail in RUN does not leave RUN. Replay continues to the last vector, then the block enters FAIL if any fail was seen, otherwise PASS.
  - fail_cycle records the first failing index.
  - Extra output fail_count (CYCLE_W) counts sampled fails; it resets to 0 and is cleared on start.
- Undefined: the block stops at the first fail as above, and fail_count does not exist.

Decomposition:
- Package trace_seq_pkg holds:
  - the seq_state_e enum (the six states);
  - typedef cycle_t (logic [CYCLE_W-1:0], default 32);
  - localparam SEQ_DEPTH_DEFAULT=16.
- One sub-module, trace_seq_mem: DEPTH x WIDTH storage with synchronous write and combinational read, addressed by wr_ptr/cycle. The FSM and counters stay in the top.

Test Plan:
1. WIDTH=1, DEPTH=4. Load 0,1,1,0 (load_last on the 4th), start, dut_fail=0. Expect stim_out 0,1,1,0 on cycles 1-4 after start, stim_valid=1 throughout. Then done=1, failed=0, cycle=4.
2. Same load. dut_fail=1 while cycle=2. Expect failed=1, fail_cycle=2, stim_out held at 1, stim_valid=0, running=0.
3. Offer 5 vectors with no load_last, DEPTH=4. Expect 4 accepted, state ARMED, load_ready=0, 5th never handshaken.
4. Assert reset while running with cycle=1. Expect next cycle: stim_out=0, stim_valid=0, cycle=0, done=0, load_ready=1.
5. From PASS, pulse start. Expect replay restarts at cycle 0 with the same vectors. From PASS, assert flush and start together. Expect IDLE, load_ready=1.
6. With TRACE_SEQ_CONT_ON_FAIL_EN, 4 vectors and dut_fail high at cycles 1 and 3. Expect full replay, FAIL, fail_cycle=1, fail_count=2.
